// File: rtl/bmu_issue_fifo.sv
// Decode-to-BMU issue buffer: first-word-fall-through FIFO of ALU packets plus operands.
// Optional per-entry even parity when BMU_ISSUE_PARITY_EN is defined.
module bmu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [41:0]   in_ap,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [41:0]   out_ap,
  output logic [31:0]   out_a,
  output logic [31:0]   out_b,
  output logic [CW-1:0] count,
  output logic          out_par_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bmu_issue_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [41:0]   ap_mem [DEPTH];
  logic [31:0]   a_mem  [DEPTH];
  logic [31:0]   b_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Full/empty come from the occupancy counter so pointer equality is never ambiguous.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ap_mem[wr_ptr] <= in_ap;
      a_mem[wr_ptr]  <= in_a;
      b_mem[wr_ptr]  <= in_b;
    end
  end

  // Head is read straight from storage; stale contents are masked while empty.
  always_comb begin
    out_ap = '0;
    out_a  = '0;
    out_b  = '0;
    if (out_valid) begin
      out_ap = ap_mem[rd_ptr];
      out_a  = a_mem[rd_ptr];
      out_b  = b_mem[rd_ptr];
    end
  end

`ifdef BMU_ISSUE_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !rst) par_mem[wr_ptr] <= ^{in_ap, in_a, in_b};
  end

  always_comb begin
    out_par_err = 1'b0;
    if (out_valid)
      out_par_err = ((^{ap_mem[rd_ptr], a_mem[rd_ptr], b_mem[rd_ptr]}) != par_mem[rd_ptr]);
  end
`else
  assign out_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_bmu_issue_fifo.sv
// Self-checking bench for bmu_issue_fifo: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_bmu_issue_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  // One-hot op positions inside the 42-bit packet used by the directed tests.
  localparam int ADD = 0, CLZ = 1, CTZ = 2, CPOP = 3, ROL = 4, SH1ADD = 5, NONE = -1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [41:0]   in_ap = '0;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [41:0]   out_ap;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [CW-1:0] count;
  logic          out_par_err;

  int vectors = 0;
  int miscompares = 0;

  bmu_issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ap(in_ap), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ap(out_ap), .out_a(out_a), .out_b(out_b),
    .count(count), .out_par_err(out_par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl; logic iv; logic ordy; int op; logic [31:0] a; logic [31:0] b;
    int e_cnt; logic e_ov; logic e_ir; int e_op; logic [31:0] e_a; logic [31:0] e_b;
  } vec_t;

  typedef struct packed {
    logic [41:0] ap; logic [31:0] a; logic [31:0] b;
  } ent_t;

  function automatic logic [41:0] pkt(input int op);
    logic [41:0] p;
    p = '0;
    if (op >= 0) p[op] = 1'b1;
    return p;
  endfunction

  task automatic step(input logic rs, input logic fl, input logic iv, input logic ordy,
                      input logic [41:0] ap, input logic [31:0] a, input logic [31:0] b);
    rst = rs; flush = fl; in_valid = iv; out_ready = ordy;
    in_ap = ap; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic check(input string name, input int e_cnt, input logic e_ov, input logic e_ir,
                       input logic [41:0] e_ap, input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic e_pe);
    vectors++;
    if (int'(count) != e_cnt || out_valid !== e_ov || in_ready !== e_ir ||
        out_ap !== e_ap || out_a !== e_a || out_b !== e_b || out_par_err !== e_pe) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d ov=%b ir=%b ap=%h a=%h b=%h pe=%b, want cnt=%0d ov=%b ir=%b ap=%h a=%h b=%h pe=%b",
               name, count, out_valid, in_ready, out_ap, out_a, out_b, out_par_err,
               e_cnt, e_ov, e_ir, e_ap, e_a, e_b, e_pe);
    end
  endtask

  vec_t tbl[$];

  initial begin
    ent_t q[$];
    ent_t e;

    // Directed table: each row is the stimulus for one cycle and the state seen after it.
    //           fl  iv  or  op      a    b     cnt ov  ir  head  a    b
    tbl.push_back('{0, 0, 0, NONE,   0,   0,    0, 0, 1, NONE,   0,   0});
    tbl.push_back('{0, 1, 0, ADD,    5,   3,    1, 1, 1, ADD,    5,   3});
    tbl.push_back('{0, 0, 0, NONE,   0,   0,    1, 1, 1, ADD,    5,   3});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    0, 0, 1, NONE,   0,   0});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    0, 0, 1, NONE,   0,   0});
    tbl.push_back('{0, 1, 0, CLZ,   10,  11,    1, 1, 1, CLZ,   10,  11});
    tbl.push_back('{0, 1, 0, CTZ,   20,  21,    2, 1, 1, CLZ,   10,  11});
    tbl.push_back('{0, 1, 0, CPOP,  30,  31,    3, 1, 1, CLZ,   10,  11});
    tbl.push_back('{0, 1, 0, ROL,   40,  41,    4, 1, 0, CLZ,   10,  11});
    tbl.push_back('{0, 1, 0, SH1ADD,50,  51,    4, 1, 0, CLZ,   10,  11});
    tbl.push_back('{0, 1, 1, SH1ADD,50,  51,    3, 1, 1, CTZ,   20,  21});
    tbl.push_back('{0, 1, 0, SH1ADD,50,  51,    4, 1, 0, CTZ,   20,  21});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    3, 1, 1, CPOP,  30,  31});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    2, 1, 1, ROL,   40,  41});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    1, 1, 1, SH1ADD,50,  51});
    tbl.push_back('{0, 1, 0, CLZ,   60,  61,    2, 1, 1, SH1ADD,50,  51});
    tbl.push_back('{1, 1, 1, ADD,   99,  98,    0, 0, 1, NONE,   0,   0});
    tbl.push_back('{0, 1, 0, CTZ,    7,   8,    1, 1, 1, CTZ,    7,   8});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    0, 0, 1, NONE,   0,   0});
    tbl.push_back('{0, 1, 0, NONE,   1,   2,    1, 1, 1, NONE,   1,   2});
    tbl.push_back('{0, 0, 1, NONE,   0,   0,    0, 0, 1, NONE,   0,   0});

    step(1, 0, 0, 0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, '0);
    check("reset", 0, 0, 1, '0, '0, '0, 0);

    foreach (tbl[i]) begin
      step(0, tbl[i].fl, tbl[i].iv, tbl[i].ordy, pkt(tbl[i].op), tbl[i].a, tbl[i].b);
      check($sformatf("row%0d", i), tbl[i].e_cnt, tbl[i].e_ov, tbl[i].e_ir,
            pkt(tbl[i].e_op), tbl[i].e_a, tbl[i].e_b, 1'b0);
    end

    // Flush while full: in_ready keeps its full value during the flush cycle.
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, pkt(k), 32'(k), 32'(k));
    flush = 1'b1; in_valid = 1'b1; in_ap = pkt(ROL); #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_full_ir: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full", 0, 0, 1, '0, '0, '0, 0);

    // Reset mid-operation, then reset with flush and a push: both leave the reset state.
    step(0, 0, 1, 0, pkt(CPOP), 32'h11, 32'h22);
    step(0, 0, 1, 0, pkt(ROL), 32'h33, 32'h44);
    step(1, 0, 1, 1, pkt(ADD), 32'h55, 32'h66);
    check("rst_mid", 0, 0, 1, '0, '0, '0, 0);
    step(0, 0, 1, 0, pkt(CLZ), 32'h77, 32'h88);
    step(1, 1, 1, 1, pkt(ADD), 32'h99, 32'haa);
    check("rst_flush", 0, 0, 1, '0, '0, '0, 0);
    step(0, 0, 1, 0, pkt(CTZ), 32'hbb, 32'hcc);
    check("post_rst_push", 1, 1, 1, pkt(CTZ), 32'hbb, 32'hcc, 0);
    step(0, 0, 0, 1, '0, '0, '0);
    check("post_rst_pop", 0, 0, 1, '0, '0, '0, 0);

`ifdef BMU_ISSUE_PARITY_EN
    // Corrupt the stored parity of entry 0 and watch it flag only while at the head.
    step(1, 0, 0, 0, '0, '0, '0);
    step(0, 0, 1, 0, pkt(ADD), 32'hFFFF_0000, 32'h0);
    dut.par_mem[0] = ~dut.par_mem[0];
    #1;
    check("par_bad", 1, 1, 1, pkt(ADD), 32'hFFFF_0000, 32'h0, 1);
    step(0, 0, 1, 0, pkt(CLZ), 32'h0000_0007, 32'h1);
    check("par_bad_hold", 2, 1, 1, pkt(ADD), 32'hFFFF_0000, 32'h0, 1);
    step(0, 0, 0, 1, '0, '0, '0);
    check("par_clean", 1, 1, 1, pkt(CLZ), 32'h0000_0007, 32'h1, 0);
    step(0, 0, 0, 1, '0, '0, '0);
`endif

    // Randomized traffic against a queue model of the buffer.
    step(1, 0, 0, 0, '0, '0, '0);
    q.delete();
    for (int n = 0; n < 2000; n++) begin
      logic rs, fl, iv, ordy;
      logic [41:0] ap;
      logic [31:0] a, b;
      int sz;
      rs   = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 29) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ap   = {10'($urandom), $urandom};
      if ($urandom_range(0, 9) == 0) ap = '0;
      a = $urandom; b = $urandom;
      sz = q.size();
      step(rs, fl, iv, ordy, ap, a, b);
      if (rs || fl) q.delete();
      else begin
        if (ordy && sz > 0) void'(q.pop_front());
        if (iv && sz < int'(DEPTH)) q.push_back('{ap, a, b});
      end
      if (q.size() > 0) begin
        e = q[0];
        check($sformatf("rand%0d", n), q.size(), 1, q.size() < int'(DEPTH), e.ap, e.a, e.b, 0);
      end else
        check($sformatf("rand%0d", n), 0, 0, 1, '0, '0, '0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
